// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the 7-segment scan driver.
//   SEG_OFF   : active-low pattern with every segment dark
//   SEG_ALL   : active-low pattern with every segment lit (lamp test)
//   HEX_SEG   : hex digit 0..F to active-low segments, bit0=a .. bit6=g
//   cnt_width : ceil(log2(value)), never less than 1, for sizing counters
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_ALL = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the user-side controls and the board-side pin outputs of the
// 7-segment scan driver.
//   load, data, digit_en, enable, seg7all_on, blink : driven by user logic
//   seg, dig_sel, frame_done                        : driven by the driver
// Modports: master = user logic side, slave = the driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    enable;
    logic                    seg7all_on;
    logic                    blink;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output load, data, digit_en, enable, seg7all_on, blink,
        input  seg, dig_sel, frame_done
    );

    modport slave (
        input  load, data, digit_en, enable, seg7all_on, blink,
        output seg, dig_sel, frame_done
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low 7-segment pattern.
//   nibble : 4-bit hex value
//   seg    : segments g..a (bit6..bit0), active-low
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed N-digit hex 7-segment driver with a double-buffered
// display word. New data is taken into a shadow buffer on load and copied to
// the active buffer only at a frame wrap, so a frame never mixes two words.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : seg7_scan_driver_if.slave
//          load/data     - shadow buffer write strobe and hex nibbles
//          digit_en      - per-digit enable (0 blanks that digit)
//          enable        - global enable (0 blanks the whole display)
//          seg7all_on    - lamp test, all segments lit on the scanned digit
//          blink         - blank enabled digits during alternate blink phases
//          seg           - segments g..a, active-low, registered
//          dig_sel       - one-hot active-low digit select, registered
//          frame_done    - one-cycle pulse after each frame wrap
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shown). Without it zeros are displayed normally.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    localparam int PRE_W  = cnt_width(SCAN_DIV);
    localparam int IDX_W  = cnt_width(NUM_DIGITS);
    localparam int FRM_W  = cnt_width(BLINK_FRAMES);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      scan_idx;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;
    logic [DATA_W-1:0]     shadow;
    logic [DATA_W-1:0]     active;
    logic                  pending;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_sel_q;
    logic                  frame_done_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib [NUM_DIGITS];
    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg;
    logic                  lz_blank;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_d;

    assign tick = (prescaler == PRE_LAST);
    assign wrap = tick && (scan_idx == IDX_LAST);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = active[4*g +: 4];
    end

    assign cur_nib = nib[scan_idx];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] upper_zero;

    always_comb begin : p_upper_zero
        logic all_zero;
        all_zero   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (nib[i] == 4'h0);
            upper_zero[i] = all_zero;
        end
    end

    assign lz_blank = upper_zero[scan_idx] && (scan_idx != '0);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_d     = SEG_OFF;
        dig_sel_d = '1;
        if (bus.enable) begin
            dig_sel_d = ~(NUM_DIGITS'(1) << scan_idx);
            if (bus.seg7all_on) begin
                seg_d = SEG_ALL;
            end else if (!bus.digit_en[scan_idx] || (bus.blink && blink_phase) || lz_blank) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            scan_idx     <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_sel_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;

            if (tick) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end

            frame_done_q <= wrap;

            if (wrap) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // A load coinciding with the wrap goes straight to the active
            // buffer so the very next frame already shows it.
            if (bus.load && wrap) begin
                active  <= bus.data;
                shadow  <= bus.data;
                pending <= 1'b0;
            end else if (bus.load) begin
                shadow  <= bus.data;
                pending <= 1'b1;
            end else if (wrap && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end

            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2 (16 clk per frame). Expected (dig_sel, seg, frame_done)
// triples are queued per frame and popped one per clock on the falling edge.
// Honours LEADING_ZERO_BLANK_EN when computing expected segments.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] dsel;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fcnt        = 0;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Frame wraps seen since reset; at the falling edge where frame_done is
    // high, the frame just started is number fcnt+1.
    always @(posedge clk) begin
        if (rst) fcnt <= 0;
        else if (bus.frame_done === 1'b1) fcnt <= fcnt + 1;
    end

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
        logic [3:0] nib;
        nib = d[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i != 0 && (d >> (4*i)) == 16'h0) return 7'h7F;
`endif
        return HEX[nib];
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] en,
                              input bit on, input bit all, input bit blank);
        exp_t e;
        for (int j = 0; j < N; j++) begin
            for (int c = 0; c < 4; c++) begin
                e.fd = (j == N - 1 && c == 3);
                if (!on) begin
                    e.dsel = 4'hF;
                    e.seg  = 7'h7F;
                end else begin
                    e.dsel    = 4'hF;
                    e.dsel[j] = 1'b0;
                    if (all) e.seg = 7'h00;
                    else if (!en[j] || blank) e.seg = 7'h7F;
                    else e.seg = exp_seg(d, j);
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] d);
        @(posedge clk); #1;
        bus.data = d;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    // Returns on the falling edge where frame_done is high.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_done !== 1'b1 && n < 64);
        if (bus.frame_done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s sync: frame_done not seen within 64 clk", tag);
        end
    endtask

    task automatic test_reset;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.seg !== 7'h7F || bus.dig_sel !== 4'hF || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: seg=%h dig_sel=%h fd=%b, want 7f f 0", bus.seg, bus.dig_sel, bus.frame_done);
        end
        rst = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                vectors++;
                if (bus.seg !== 7'h7F || bus.dig_sel !== 4'hF) begin
                    miscompares++;
                    $display("FAIL reset_first_cycle: seg=%h dig_sel=%h, want 7f f", bus.seg, bus.dig_sel);
                end
            end
        end while (bus.frame_done !== 1'b1 && cyc < 40);
        vectors++;
        if (cyc != 16) begin
            miscompares++;
            $display("FAIL reset_first_frame: frame_done after %0d clk, want 16", cyc);
        end
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (bus.frame_done !== 1'b1 && cyc < 40);
        vectors++;
        if (cyc != 16) begin
            miscompares++;
            $display("FAIL frame_period: %0d clk between frame_done, want 16", cyc);
        end
    endtask

    task automatic test_scan;
        exp_t e;
        bus.enable   = 1'b1;
        bus.digit_en = 4'hF;
        pulse_load(16'h1A30);
        wait_frame("scan");
        push_frame(16'h1A30, 4'hF, 1, 0, 0);
        repeat (16) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL scan: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
    endtask

    task automatic test_tear_free;
        exp_t e;
        wait_frame("tear");
        push_frame(16'h1A30, 4'hF, 1, 0, 0);
        push_frame(16'h2222, 4'hF, 1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (i == 7) begin
                bus.data = 16'h2222;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL tear_free[%0d]: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         i, bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
    endtask

    task automatic test_load_on_wrap;
        exp_t e;
        wait_frame("load_on_wrap");
        push_frame(16'h2222, 4'hF, 1, 0, 0);
        push_frame(16'h000F, 4'hF, 1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (i == 14) begin
                bus.data = 16'h000F;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL load_on_wrap[%0d]: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         i, bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        vectors++;
        if (dut.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL load_on_wrap_pending: pending=%b, want 0", dut.pending);
        end
    endtask

    task automatic test_controls;
        exp_t e;
        bus.seg7all_on = 1'b1;
        bus.digit_en   = 4'h0;
        pulse_load(16'h8421);
        wait_frame("controls");
        push_frame(16'h8421, 4'h0, 1, 1, 0);
        repeat (16) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL lamp_test: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        bus.seg7all_on = 1'b0;
        bus.enable     = 1'b0;
        push_frame(16'h8421, 4'hF, 0, 0, 0);
        repeat (16) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL global_off: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        bus.enable   = 1'b1;
        bus.digit_en = 4'b0101;
        push_frame(16'h8421, 4'b0101, 1, 0, 0);
        repeat (16) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL digit_en: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        bus.digit_en = 4'hF;
    endtask

    task automatic test_blink;
        exp_t e;
        int   k;
        int   guard;
        bus.blink = 1'b1;
        wait_frame("blink");
        k = fcnt + 1;
        for (int j = 0; j < 4; j++) push_frame(16'h8421, 4'hF, 1, 0, ((k + j) / 2) % 2 == 1);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL blink[%0d]: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         i, bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        // Move into a blanked frame, then drop blink partway through digit 0.
        k = fcnt + 1;
        guard = 0;
        while (((k / 2) % 2) == 0 && guard < 4) begin
            wait_frame("blink_off");
            k = fcnt + 1;
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            e.fd      = 1'b0;
            e.dsel    = 4'hF;
            e.dsel[i / 4] = 1'b0;
            e.seg     = (i <= 3) ? 7'h7F : exp_seg(16'h8421, i / 4);
            sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) bus.blink = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL blink_off[%0d]: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         i, bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
        bus.blink = 1'b0;
    endtask

    task automatic test_leading_zero;
        exp_t        e;
        logic [15:0] pats [2];
        pats[0] = 16'h0050;
        pats[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            pulse_load(pats[p]);
            wait_frame("leading_zero");
            push_frame(pats[p], 4'hF, 1, 0, 0);
            repeat (16) begin
                @(negedge clk);
                e = sb.pop_front();
                vectors++;
                if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                    miscompares++;
                    $display("FAIL leading_zero %h: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                             pats[p], bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        exp_t e;
        pulse_load(16'h1A30);
        wait_frame("mid_reset");
        @(posedge clk); #1;
        bus.data = 16'hBEEF;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.seg !== 7'h7F || bus.dig_sel !== 4'hF || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_out: seg=%h dig_sel=%h fd=%b, want 7f f 0", bus.seg, bus.dig_sel, bus.frame_done);
        end
        vectors++;
        if (dut.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_pending: pending=%b, want 0", dut.pending);
        end
        @(posedge clk); #1 rst = 1'b0;
        wait_frame("mid_reset");
        push_frame(16'h0000, 4'hF, 1, 0, 0);
        repeat (16) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (bus.seg !== e.seg || bus.dig_sel !== e.dsel || bus.frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL mid_reset_frame: got seg=%h dig_sel=%h fd=%b, want seg=%h dig_sel=%h fd=%b",
                         bus.seg, bus.dig_sel, bus.frame_done, e.seg, e.dsel, e.fd);
            end
        end
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.data       = '0;
        bus.digit_en   = '0;
        bus.enable     = 1'b0;
        bus.seg7all_on = 1'b0;
        bus.blink      = 1'b0;
        test_reset();
        test_scan();
        test_tear_free();
        test_load_on_wrap();
        test_controls();
        test_blink();
        test_leading_zero();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
